// File: rtl/pong_pkg.sv
// ============================================================================
// Module      : pong_pkg
// Description : Shared playfield geometry, coordinate widths and the
//               collision FSM state encoding for the pong datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pong_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int BAR_WIDTH  = 96;
    localparam int BAR_HEIGHT = 8;
    localparam int P1_BAR_Y   = 430;
    localparam int P2_BAR_Y   = 20;
    localparam int BALL_SIZE  = 8;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    // One bit wider than X_W so that coordinate + extent never wraps.
    localparam int EXT_W = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        REPORT = 2'd2,
        OVER   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/collision_detect_if.sv
// ============================================================================
// Module      : collision_detect_if
// Description : Position inputs and event/score outputs of collision_detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface collision_detect_if;
    import pong_pkg::*;

    logic           frame_tick;
    logic [X_W-1:0] ball_x;
    logic [Y_W-1:0] ball_y;
    logic [X_W-1:0] p1_bar_x;
    logic [X_W-1:0] p2_bar_x;

    logic           paddle_collision;
    logic           paddle_id;
    logic           wall_collision;
    logic           p1_point;
    logic           p2_point;
    logic [3:0]     score_p1;
    logic [3:0]     score_p2;
    logic           game_over;
    logic [7:0]     rally_count;

    modport master (
        output frame_tick, ball_x, ball_y, p1_bar_x, p2_bar_x,
        input  paddle_collision, paddle_id, wall_collision, p1_point,
               p2_point, score_p1, score_p2, game_over, rally_count
    );

    modport slave (
        input  frame_tick, ball_x, ball_y, p1_bar_x, p2_bar_x,
        output paddle_collision, paddle_id, wall_collision, p1_point,
               p2_point, score_p1, score_p2, game_over, rally_count
    );

endinterface

`default_nettype wire

// File: rtl/rect_overlap.sv
// ============================================================================
// Module      : rect_overlap
// Description : Combinational overlap test of two axis-aligned rectangles
//               using half-open extents [x, x+w) x [y, y+h).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_overlap
    import pong_pkg::*;
(
    input  wire logic [EXT_W-1:0] i_a_x,
    input  wire logic [EXT_W-1:0] i_a_y,
    input  wire logic [EXT_W-1:0] i_a_w,
    input  wire logic [EXT_W-1:0] i_a_h,
    input  wire logic [EXT_W-1:0] i_b_x,
    input  wire logic [EXT_W-1:0] i_b_y,
    input  wire logic [EXT_W-1:0] i_b_w,
    input  wire logic [EXT_W-1:0] i_b_h,
    output logic                  o_overlap
);

    logic w_x_ovl;
    logic w_y_ovl;

    assign w_x_ovl   = (i_a_x < (i_b_x + i_b_w)) && (i_b_x < (i_a_x + i_a_w));
    assign w_y_ovl   = (i_a_y < (i_b_y + i_b_h)) && (i_b_y < (i_a_y + i_a_h));
    assign o_overlap = w_x_ovl && w_y_ovl;

endmodule

`default_nettype wire

// File: rtl/collision_detect.sv
// ============================================================================
// Module      : collision_detect
// Description : Per-frame paddle/wall/miss event generator with scoring.
//               Optional rally counter enabled by macro COLLISION_RALLY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module collision_detect
    import pong_pkg::*;
#(
    parameter int WIN_SCORE = 7
) (
    input  wire logic         clk,
    input  wire logic         reset,
    collision_detect_if.slave bus
);

    localparam logic [EXT_W-1:0] c_ball     = EXT_W'(BALL_SIZE);
    localparam logic [EXT_W-1:0] c_bar_w    = EXT_W'(BAR_WIDTH);
    localparam logic [EXT_W-1:0] c_bar_h    = EXT_W'(BAR_HEIGHT);
    localparam logic [EXT_W-1:0] c_p1_y     = EXT_W'(P1_BAR_Y);
    localparam logic [EXT_W-1:0] c_p2_y     = EXT_W'(P2_BAR_Y);
    localparam logic [EXT_W-1:0] c_screen_w = EXT_W'(SCREEN_W);
    localparam logic [3:0]       c_win      = 4'(WIN_SCORE);

    state_t         r_state;
    logic [X_W-1:0] r_ball_x;
    logic [Y_W-1:0] r_ball_y;
    logic [X_W-1:0] r_p1_x;
    logic [X_W-1:0] r_p2_x;

    logic r_f_p1, r_f_p2, r_f_wall, r_f_top, r_f_bot;

    logic       r_paddle_collision;
    logic       r_paddle_id;
    logic       r_wall_collision;
    logic       r_p1_point;
    logic       r_p2_point;
    logic [3:0] r_score_p1;
    logic [3:0] r_score_p2;
    logic       r_game_over;

    logic [EXT_W-1:0] w_bx;
    logic [EXT_W-1:0] w_by;
    logic             w_c_p1, w_c_p2, w_c_wall, w_c_top, w_c_bot;
    logic             w_new_p1, w_new_p2, w_pad;
    logic             w_wall, w_p1_pt, w_p2_pt;
    logic [3:0]       w_score_p1_nxt;
    logic [3:0]       w_score_p2_nxt;
    logic             w_reach_win;

    assign w_bx = {1'b0, r_ball_x};
    assign w_by = {2'b0, r_ball_y};

    rect_overlap u_hit_p1 (
        .i_a_x     (w_bx),
        .i_a_y     (w_by),
        .i_a_w     (c_ball),
        .i_a_h     (c_ball),
        .i_b_x     ({1'b0, r_p1_x}),
        .i_b_y     (c_p1_y),
        .i_b_w     (c_bar_w),
        .i_b_h     (c_bar_h),
        .o_overlap (w_c_p1)
    );

    rect_overlap u_hit_p2 (
        .i_a_x     (w_bx),
        .i_a_y     (w_by),
        .i_a_w     (c_ball),
        .i_a_h     (c_ball),
        .i_b_x     ({1'b0, r_p2_x}),
        .i_b_y     (c_p2_y),
        .i_b_w     (c_bar_w),
        .i_b_h     (c_bar_h),
        .o_overlap (w_c_p2)
    );

    assign w_c_wall = (w_bx == '0) || ((w_bx + c_ball) >= c_screen_w);
    assign w_c_top  = (w_by < c_p2_y);
    assign w_c_bot  = ((w_by + c_ball) > (c_p1_y + c_bar_h));

    // Events fire only on the rising edge of each contact condition.
    assign w_new_p1 = w_c_p1 && !r_f_p1;
    assign w_new_p2 = w_c_p2 && !r_f_p2;
    assign w_pad    = w_new_p1 || w_new_p2;
    assign w_wall   = w_c_wall && !r_f_wall;
    assign w_p1_pt  = w_c_top && !r_f_top && !w_pad;
    assign w_p2_pt  = w_c_bot && !r_f_bot && !w_pad;

    assign w_score_p1_nxt = (r_p1_point && (r_score_p1 != c_win)) ? r_score_p1 + 4'd1 : r_score_p1;
    assign w_score_p2_nxt = (r_p2_point && (r_score_p2 != c_win)) ? r_score_p2 + 4'd1 : r_score_p2;
    assign w_reach_win    = (w_score_p1_nxt == c_win) || (w_score_p2_nxt == c_win);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= IDLE;
            r_ball_x           <= '0;
            r_ball_y           <= '0;
            r_p1_x             <= '0;
            r_p2_x             <= '0;
            r_f_p1             <= 1'b0;
            r_f_p2             <= 1'b0;
            r_f_wall           <= 1'b0;
            r_f_top            <= 1'b0;
            r_f_bot            <= 1'b0;
            r_paddle_collision <= 1'b0;
            r_paddle_id        <= 1'b0;
            r_wall_collision   <= 1'b0;
            r_p1_point         <= 1'b0;
            r_p2_point         <= 1'b0;
            r_score_p1         <= '0;
            r_score_p2         <= '0;
            r_game_over        <= 1'b0;
        end else begin
            r_paddle_collision <= 1'b0;
            r_wall_collision   <= 1'b0;
            r_p1_point         <= 1'b0;
            r_p2_point         <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.frame_tick) begin
                        r_ball_x <= bus.ball_x;
                        r_ball_y <= bus.ball_y;
                        r_p1_x   <= bus.p1_bar_x;
                        r_p2_x   <= bus.p2_bar_x;
                        r_state  <= EVAL;
                    end
                end
                EVAL: begin
                    r_paddle_collision <= w_pad;
                    r_wall_collision   <= w_wall;
                    r_p1_point         <= w_p1_pt;
                    r_p2_point         <= w_p2_pt;
                    if (w_pad) begin
                        r_paddle_id <= !w_new_p1;
                    end
                    r_f_p1   <= w_c_p1;
                    r_f_p2   <= w_c_p2;
                    r_f_wall <= w_c_wall;
                    r_f_top  <= w_c_top;
                    r_f_bot  <= w_c_bot;
                    r_state  <= REPORT;
                end
                REPORT: begin
                    r_score_p1 <= w_score_p1_nxt;
                    r_score_p2 <= w_score_p2_nxt;
                    if (w_reach_win) begin
                        r_game_over <= 1'b1;
                        r_state     <= OVER;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                OVER: begin
                    r_state <= OVER;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef COLLISION_RALLY_EN
    logic [7:0] r_rally;

    // Updated alongside the pulse registers so the count changes in REPORT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rally <= '0;
        end else if (r_state == EVAL) begin
            if (w_p1_pt || w_p2_pt) begin
                r_rally <= '0;
            end else if (w_pad && (r_rally != 8'hFF)) begin
                r_rally <= r_rally + 8'd1;
            end
        end
    end

    assign bus.rally_count = r_rally;
`else
    assign bus.rally_count = '0;
`endif

    assign bus.paddle_collision = r_paddle_collision;
    assign bus.paddle_id        = r_paddle_id;
    assign bus.wall_collision   = r_wall_collision;
    assign bus.p1_point         = r_p1_point;
    assign bus.p2_point         = r_p2_point;
    assign bus.score_p1         = r_score_p1;
    assign bus.score_p2         = r_score_p2;
    assign bus.game_over        = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_collision_detect.sv
// ============================================================================
// Module      : tb_collision_detect
// Description : Self-checking bench for collision_detect with a frame-level
//               reference model and randomized positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_collision_detect;

`ifdef COLLISION_RALLY_EN
    localparam bit RALLY_EN = 1'b1;
`else
    localparam bit RALLY_EN = 1'b0;
`endif
    localparam int WIN = 7;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    collision_detect_if bus();

    collision_detect #(.WIN_SCORE(WIN)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Frame-level model state: contact memories, scores, last paddle, rally.
    bit m_f1, m_f2, m_fw, m_ft, m_fb;
    int m_s1, m_s2, m_rally;
    bit m_over, m_id;

    function automatic bit hit(input int bx, input int by, input int barx, input int bary);
        return (bx < barx + 96) && (barx < bx + 8) && (by < bary + 8) && (bary < by + 8);
    endfunction

    task automatic model_reset();
        m_f1 = 0; m_f2 = 0; m_fw = 0; m_ft = 0; m_fb = 0;
        m_s1 = 0; m_s2 = 0; m_rally = 0; m_over = 0; m_id = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.frame_tick = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Drives one frame (3 cycles after the tick) and checks the result window.
    task automatic do_frame(input int bx, input int by, input int p1x, input int p2x, input bit extra);
        bit h1, h2, cw, ct, cb, np1, np2;
        bit e_pad, e_wall, e_p1, e_p2;
        logic [3:0] exp_vec, got_vec;
        logic [7:0] exp_rally;
        h1 = hit(bx, by, p1x, 430);
        h2 = hit(bx, by, p2x, 20);
        cw = (bx == 0) || (bx + 8 >= 640);
        ct = by < 20;
        cb = by + 8 > 438;
        e_pad = 0; e_wall = 0; e_p1 = 0; e_p2 = 0;
        if (!m_over) begin
            np1 = h1 && !m_f1;
            np2 = h2 && !m_f2;
            e_pad = np1 || np2;
            if (e_pad) m_id = !np1;
            e_wall = cw && !m_fw;
            e_p1 = ct && !m_ft && !e_pad;
            e_p2 = cb && !m_fb && !e_pad;
            m_f1 = h1; m_f2 = h2; m_fw = cw; m_ft = ct; m_fb = cb;
            if (e_p1 || e_p2) m_rally = 0;
            else if (e_pad && m_rally < 255) m_rally++;
        end
        exp_vec = {e_pad, e_wall, e_p1, e_p2};
        exp_rally = RALLY_EN ? 8'(m_rally) : 8'd0;

        @(negedge clk);
        bus.ball_x = 10'(bx);
        bus.ball_y = 9'(by);
        bus.p1_bar_x = 10'(p1x);
        bus.p2_bar_x = 10'(p2x);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = extra;
        got_vec = {bus.paddle_collision, bus.wall_collision, bus.p1_point, bus.p2_point};
        n_vec++;
        if (got_vec !== 4'b0000) begin
            n_err++;
            $display("FAIL early_pulse ball=(%0d,%0d) got=%b want=0000", bx, by, got_vec);
        end
        @(negedge clk);
        bus.frame_tick = 1'b0;
        got_vec = {bus.paddle_collision, bus.wall_collision, bus.p1_point, bus.p2_point};
        n_vec++;
        if (got_vec !== exp_vec) begin
            n_err++;
            $display("FAIL pulses{pad,wall,p1,p2} ball=(%0d,%0d) p1x=%0d p2x=%0d got=%b want=%b",
                     bx, by, p1x, p2x, got_vec, exp_vec);
        end
        n_vec++;
        if (bus.paddle_id !== m_id) begin
            n_err++;
            $display("FAIL paddle_id got=%b want=%b", bus.paddle_id, m_id);
        end
        n_vec++;
        if (bus.rally_count !== exp_rally) begin
            n_err++;
            $display("FAIL rally_count got=%0d want=%0d", bus.rally_count, exp_rally);
        end
        if (!m_over) begin
            if (e_p1 && m_s1 < WIN) m_s1++;
            if (e_p2 && m_s2 < WIN) m_s2++;
            m_over = (m_s1 == WIN) || (m_s2 == WIN);
        end
        @(negedge clk);
        n_vec++;
        if (bus.score_p1 !== 4'(m_s1) || bus.score_p2 !== 4'(m_s2) || bus.game_over !== m_over) begin
            n_err++;
            $display("FAIL scores got=%0d/%0d/go%b want=%0d/%0d/go%b",
                     bus.score_p1, bus.score_p2, bus.game_over, m_s1, m_s2, m_over);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if ({bus.paddle_collision, bus.paddle_id, bus.wall_collision, bus.p1_point, bus.p2_point,
             bus.score_p1, bus.score_p2, bus.game_over, bus.rally_count} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs some output nonzero (scores %0d/%0d go=%b rally=%0d)",
                     bus.score_p1, bus.score_p2, bus.game_over, bus.rally_count);
        end
    endtask

    task automatic test_paddle();
        do_frame(300, 422, 250, 500, 0);
        do_frame(300, 424, 250, 500, 0);
        do_frame(300, 424, 250, 500, 0);
        do_frame(300, 200, 250, 500, 0);
        do_frame(300, 22, 250, 250, 0);
        do_frame(300, 200, 250, 250, 0);
    endtask

    task automatic test_wall();
        do_frame(0, 200, 500, 500, 0);
        do_frame(300, 200, 500, 500, 0);
        do_frame(632, 200, 500, 500, 0);
        do_frame(300, 200, 500, 500, 0);
        do_frame(631, 200, 500, 500, 0);
        do_frame(0, 424, 0, 500, 0);
        do_frame(300, 200, 500, 500, 0);
    endtask

    task automatic test_miss();
        do_frame(300, 10, 250, 0, 0);
        do_frame(300, 10, 250, 0, 0);
        do_frame(300, 10, 250, 0, 0);
        do_frame(300, 200, 250, 0, 0);
        do_frame(300, 16, 250, 250, 0);
        do_frame(300, 200, 250, 0, 0);
        do_frame(300, 435, 0, 0, 0);
        do_frame(300, 200, 0, 0, 0);
    endtask

    task automatic test_game_over();
        apply_reset();
        for (int i = 0; i < WIN; i++) begin
            do_frame(300, 10, 0, 500, 0);
            do_frame(300, 200, 0, 500, 0);
        end
        n_vec++;
        if (bus.game_over !== 1'b1 || bus.score_p1 !== 4'(WIN)) begin
            n_err++;
            $display("FAIL game_over got=%b score_p1=%0d want=1 score_p1=%0d", bus.game_over, bus.score_p1, WIN);
        end
        do_frame(0, 10, 0, 500, 0);
        do_frame(300, 435, 0, 0, 0);
        test_reset();
    endtask

    task automatic test_tick_in_eval();
        logic [3:0] got_vec;
        do_frame(300, 200, 500, 500, 0);
        do_frame(0, 200, 500, 500, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got_vec = {bus.paddle_collision, bus.wall_collision, bus.p1_point, bus.p2_point};
            n_vec++;
            if (got_vec !== 4'b0000) begin
                n_err++;
                $display("FAIL ignored_tick cycle=%0d got=%b want=0000", i, got_vec);
            end
        end
    endtask

    task automatic test_reset_in_eval();
        do_frame(300, 10, 500, 500, 0);
        @(negedge clk);
        bus.ball_x = 10'd0;
        bus.ball_y = 9'd5;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({bus.paddle_collision, bus.wall_collision, bus.p1_point, bus.p2_point,
                 bus.score_p1, bus.score_p2, bus.game_over, bus.rally_count} !== '0) begin
                n_err++;
                $display("FAIL reset_in_eval cycle=%0d outputs not cleared score_p1=%0d", i, bus.score_p1);
            end
            @(negedge clk);
        end
        do_frame(0, 5, 500, 500, 0);
        do_frame(300, 200, 500, 500, 0);
    endtask

    task automatic test_rally();
        apply_reset();
        do_frame(300, 424, 250, 500, 0);
        do_frame(300, 200, 250, 250, 0);
        do_frame(300, 22, 250, 250, 0);
        do_frame(300, 200, 250, 250, 0);
        do_frame(300, 424, 250, 500, 0);
        do_frame(300, 200, 500, 500, 0);
        do_frame(300, 10, 500, 500, 0);
    endtask

    task automatic test_random();
        int bx, by, p1x, p2x;
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            p1x = $urandom_range(0, 544);
            p2x = $urandom_range(0, 544);
            case ($urandom_range(0, 3))
                0: begin bx = p1x + $urandom_range(0, 110) - 12; by = $urandom_range(418, 440); end
                1: begin bx = p2x + $urandom_range(0, 110) - 12; by = $urandom_range(8, 30); end
                2: begin bx = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2) : $urandom_range(630, 632); by = $urandom_range(0, 471); end
                default: begin bx = $urandom_range(0, 632); by = $urandom_range(0, 471); end
            endcase
            if (bx < 0) bx = 0;
            if (bx > 632) bx = 632;
            do_frame(bx, by, p1x, p2x, 0);
            if (m_over && ($urandom_range(0, 3) == 0)) apply_reset();
        end
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.ball_x = '0;
        bus.ball_y = '0;
        bus.p1_bar_x = '0;
        bus.p2_bar_x = '0;
        model_reset();
        test_reset();
        test_paddle();
        test_wall();
        test_miss();
        test_game_over();
        test_tick_in_eval();
        test_reset_in_eval();
        test_rally();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
